alu_bist: RTL and testbench
===========================

// Module: alu_bist
// PURPOSE
//  Self-checking stimulus engine for the combinational ALU: drives reg_one/reg_two/op,
//  samples result and compares against an internal golden model, op by op.
//  Sits beside the single-cycle datapath as the initiator for the ALU interface;
//  used for in-system self-test and for simulation regression of the ALU.
// PARAMETERS
//  VECTORS        64            vectors per op (1..65535)
//  SETTLE_CYCLES  1             cycles between operand drive and result sample (>=1)
//  SEED           32'hACE1_2468 LFSR seed; value 0 replaced by 32'h1
//  STOP_ON_FAIL   0             1: end run at first mismatch; 0: run all vectors
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   level; sampled in IDLE/DONE, begins a run
//  alu_reg_one  out  32  ALU operand A (registered)
//  alu_reg_two  out  32  ALU operand B (registered)
//  alu_op       out  6   ALU funct code (registered)
//  alu_result   in   32  ALU result
//  busy         out  1   run in progress
//  done         out  1   run complete; held until next start or reset
//  pass         out  1   valid with done: 1 = zero mismatches
//  fail_count   out  16  total mismatches, saturates at 16'hFFFF
//  fail_op      out  6   op of first mismatch
//  fail_index   out  16  vector index of first mismatch
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge, any state incl. mid-run): state=IDLE, all outputs 0,
//    LFSR=SEED, op/vector counters 0. Reset has priority over start.
//  - Op sequence (fixed): 0 sll, 2 srl, 3 sra, 32 add, 34 sub, 36 and, 37 or,
//    38 xor, 39 nor, 42 slt, 8 jr (11 ops).
//  - Golden model, A=reg_one, B=reg_two, 32-bit wrap: sll A<<B[4:0]; srl A>>B[4:0];
//    sra $signed(A)>>>B[4:0]; add A+B; sub A-B; and/or/xor; nor ~(A|B);
//    slt {31'b0, A<B} unsigned compare; jr A.
//  - Operands: 32-bit Galois LFSR, poly x^32+x^22+x^2+x+1, stepped once per operand
//    draw (A then B). Shift ops: A from LFSR, B = vector_index mod 32.
//  - FSM: IDLE -start-> DRIVE; DRIVE (1 cyc, load alu_* regs) -> WAIT;
//    WAIT (SETTLE_CYCLES cyc) -> CHECK; CHECK (1 cyc, compare alu_result to golden
//    computed from registered operands) -> DRIVE (next vector/op) or DONE.
//    DONE -start-> DRIVE (new run).
//  - Cost: SETTLE_CYCLES+2 cycles per vector; run = 11*VECTORS*(SETTLE_CYCLES+2).
//  - Start accepted: busy=1, done=0, pass=0, fail_* cleared, LFSR reloaded with SEED,
//    so every run is bit-identical. start while busy ignored.
//  - Mismatch in CHECK: fail_count+1 (saturating); first mismatch latches fail_op,
//    fail_index; later mismatches do not overwrite. STOP_ON_FAIL=1 -> DONE next cycle.
//  - DONE entry: busy=0, done=1, pass=(fail_count==0). alu_* hold last values.
//  - Counters wrap: vector index resets to 0 on op advance; op index 10 -> DONE.
// TESTING
//  1 good ALU, VECTORS=4, SETTLE=1: start 1 cyc -> done high exactly 132 cycles
//    after start accept, pass=1, fail_count=0.
//  2 ALU xor stuck at 0, VECTORS=8: -> pass=0, fail_op=38, fail_index=0, fail_count=8.
//  3 same fault, STOP_ON_FAIL=1: -> done 1 cyc after first xor CHECK, fail_count=1,
//    no op 39 ever driven.
//  4 rst_n=0 mid-run (during op 32): -> next edge all outputs 0, IDLE; restart
//    gives the same operand sequence as a fresh run.
//  5 start held high through run: no restart while busy; after done, run
//    restarts, fail_* cleared, alu_reg_one repeats first-run vector 0.
//  6 sra check: A=32'h8000_0000, B=4 -> golden 32'hF800_0000; ALU doing srl -> fail_op=3.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test initiator for the combinational ALU. It drives
//   operands and a funct code, samples alu_result and checks it against an
//   internal golden model, one vector at a time over a fixed list of 11 ops.
// Latency: SETTLE_CYCLES+2 cycles per vector, so a full run takes
//   11*VECTORS*(SETTLE_CYCLES+2) cycles from start accept to done.
// Backpressure: none. start is a level that is sampled only in IDLE/DONE, and
//   start while busy is ignored. alu_result is trusted after SETTLE_CYCLES.
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start            begin a run (level, sampled when not busy)
//   alu_reg_one/two  registered ALU operands A/B
//   alu_op           registered ALU funct code
//   alu_result       ALU output under test
//   busy, done, pass run status; pass is valid while done is high
//   fail_count       saturating mismatch count
//   fail_op/index    op and vector index of the first mismatch
module alu_bist #(
  parameter int unsigned VECTORS       = 64,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'hACE1_2468,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] alu_reg_one,
  output logic [31:0] alu_reg_two,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [5:0]  fail_op,
  output logic [15:0] fail_index
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  // Galois mask for x^32+x^22+x^2+x+1 in right-shifting form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [3:0]  LAST_OP   = 4'd10;
  localparam logic [15:0] LAST_VEC  = 16'(VECTORS - 1);
  localparam int unsigned WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Fixed op order; funct codes of the ALU.
  function automatic logic [5:0] op_code(input logic [3:0] idx);
    logic [5:0] code;
    case (idx)
      4'd0:    code = 6'd0;   // sll
      4'd1:    code = 6'd2;   // srl
      4'd2:    code = 6'd3;   // sra
      4'd3:    code = 6'd32;  // add
      4'd4:    code = 6'd34;  // sub
      4'd5:    code = 6'd36;  // and
      4'd6:    code = 6'd37;  // or
      4'd7:    code = 6'd38;  // xor
      4'd8:    code = 6'd39;  // nor
      4'd9:    code = 6'd42;  // slt
      4'd10:   code = 6'd8;   // jr
      default: code = 6'd0;
    endcase
    return code;
  endfunction

  function automatic logic is_shift(input logic [5:0] code);
    return (code == 6'd0) || (code == 6'd2) || (code == 6'd3);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] code);
    logic [31:0] r;
    case (code)
      6'd0:    r = a << b[4:0];
      6'd2:    r = a >> b[4:0];
      6'd3:    r = 32'($signed(a) >>> b[4:0]);
      6'd32:   r = a + b;
      6'd34:   r = a - b;
      6'd36:   r = a & b;
      6'd37:   r = a | b;
      6'd38:   r = a ^ b;
      6'd39:   r = ~(a | b);
      6'd42:   r = {31'b0, (a < b)};
      6'd8:    r = a;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [3:0]        op_idx_q, op_idx_d;
  logic [15:0]       vec_idx_q, vec_idx_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       reg_one_q, reg_one_d;
  logic [31:0]       reg_two_q, reg_two_d;
  logic [5:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       fail_count_q, fail_count_d;
  logic [5:0]        fail_op_q, fail_op_d;
  logic [15:0]       fail_index_q, fail_index_d;

  logic [31:0] draw_a;
  logic [31:0] draw_b;
  logic [31:0] expected;
  logic        mismatch;
  logic [15:0] fc_next;
  logic        finish;
  logic [5:0]  next_code;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    op_idx_d     = op_idx_q;
    vec_idx_d    = vec_idx_q;
    wait_cnt_d   = wait_cnt_q;
    reg_one_d    = reg_one_q;
    reg_two_d    = reg_two_q;
    op_d         = op_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_op_d    = fail_op_q;
    fail_index_d = fail_index_q;

    draw_a    = lfsr_next(lfsr_q);
    draw_b    = lfsr_next(draw_a);
    next_code = op_code(op_idx_q);
    // Golden is computed from the operands actually presented to the ALU.
    expected  = golden(reg_one_q, reg_two_q, op_q);
    mismatch  = (alu_result != expected);
    fc_next   = fail_count_q;
    finish    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_DRIVE;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_count_d = 16'h0;
          fail_op_d    = 6'h0;
          fail_index_d = 16'h0;
          // Reloading the seed makes every run bit-identical.
          lfsr_d       = SEED_EFF;
          op_idx_d     = 4'd0;
          vec_idx_d    = 16'd0;
        end
      end

      S_DRIVE: begin
        op_d      = next_code;
        reg_one_d = draw_a;
        if (is_shift(next_code)) begin
          // Shift amount sweeps with the vector index; only A consumes the LFSR.
          reg_two_d = {27'b0, vec_idx_q[4:0]};
          lfsr_d    = draw_a;
        end else begin
          reg_two_d = draw_b;
          lfsr_d    = draw_b;
        end
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          fc_next = (fail_count_q == 16'hFFFF) ? fail_count_q : fail_count_q + 16'd1;
          // Count is zero only before the first mismatch (it saturates, never wraps).
          if (fail_count_q == 16'h0) begin
            fail_op_d    = op_q;
            fail_index_d = vec_idx_q;
          end
        end
        fail_count_d = fc_next;
        finish = (mismatch && STOP_ON_FAIL) ||
                 ((vec_idx_q == LAST_VEC) && (op_idx_q == LAST_OP));
        if (finish) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fc_next == 16'h0);
        end else begin
          state_d = S_DRIVE;
          if (vec_idx_q == LAST_VEC) begin
            vec_idx_d = 16'd0;
            op_idx_d  = op_idx_q + 4'd1;
          end else begin
            vec_idx_d = vec_idx_q + 16'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      op_idx_q     <= 4'd0;
      vec_idx_q    <= 16'd0;
      wait_cnt_q   <= '0;
      reg_one_q    <= 32'h0;
      reg_two_q    <= 32'h0;
      op_q         <= 6'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 16'h0;
      fail_op_q    <= 6'h0;
      fail_index_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      op_idx_q     <= op_idx_d;
      vec_idx_q    <= vec_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      reg_one_q    <= reg_one_d;
      reg_two_q    <= reg_two_d;
      op_q         <= op_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_op_q    <= fail_op_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign alu_reg_one = reg_one_q;
  assign alu_reg_two = reg_two_q;
  assign alu_op      = op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_count  = fail_count_q;
  assign fail_op     = fail_op_q;
  assign fail_index  = fail_index_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three instances share one clock.
//   u0: VECTORS=4, u1: VECTORS=8, u2: VECTORS=8 with STOP_ON_FAIL=1.
// Each drives a bench ALU model whose fault mode is selected at run time.
module tb_alu_bist;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        start      [3];
  logic [31:0] reg_one    [3];
  logic [31:0] reg_two    [3];
  logic [5:0]  op         [3];
  logic [31:0] result     [3];
  logic        busy       [3];
  logic        done       [3];
  logic        pass       [3];
  logic [15:0] fail_count [3];
  logic [5:0]  fail_op    [3];
  logic [15:0] fail_index [3];
  logic [1:0]  mode       [3];  // 0 good, 1 xor stuck at 0, 2 sra behaves as srl

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  logic saw39 = 1'b0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [5:0] op_at(input int p);
    logic [5:0] c;
    case (p)
      0: c = 6'd0;   1: c = 6'd2;   2: c = 6'd3;   3: c = 6'd32;
      4: c = 6'd34;  5: c = 6'd36;  6: c = 6'd37;  7: c = 6'd38;
      8: c = 6'd39;  9: c = 6'd42;  10: c = 6'd8;
      default: c = 6'd63;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] f, input logic [1:0] m);
    logic [31:0] r;
    case (f)
      6'd0:  r = a << b[4:0];
      6'd2:  r = a >> b[4:0];
      6'd3:  r = (m == 2'd2) ? (a >> b[4:0]) : 32'($signed(a) >>> b[4:0]);
      6'd32: r = a + b;
      6'd34: r = a - b;
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd38: r = (m == 2'd1) ? 32'h0 : (a ^ b);
      6'd39: r = ~(a | b);
      6'd42: r = {31'b0, (a < b)};
      6'd8:  r = a;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_bist #(
      .VECTORS      ((g == 0) ? 4 : 8),
      .SETTLE_CYCLES(1),
      .SEED         (SEED),
      .STOP_ON_FAIL (g == 2)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .start      (start[g]),
      .alu_reg_one(reg_one[g]),
      .alu_reg_two(reg_two[g]),
      .alu_op     (op[g]),
      .alu_result (result[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .fail_count (fail_count[g]),
      .fail_op    (fail_op[g]),
      .fail_index (fail_index[g])
    );
    assign result[g] = alu_model(reg_one[g], reg_two[g], op[g], mode[g]);
  end

  always @(negedge clk) if (op[2] == 6'd39) saw39 <= 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: raises start, then waits for done. cyc counts clock
  // edges after the accepting edge (-1 if the budget expires).
  task automatic run(input int i, input bit hold, input int budget, output int cyc,
                     output logic busy1, output logic [31:0] a0, output logic [31:0] b0,
                     output logic [5:0] op0);
    start[i] = 1'b1;
    cyc = -1; busy1 = 1'b0; a0 = '0; b0 = '0; op0 = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1 = busy[i];
        if (!hold) start[i] = 1'b0;
      end
      if (k == 2) begin
        a0 = reg_one[i]; b0 = reg_two[i]; op0 = op[i];
      end
      if (done[i]) begin
        cyc = k - 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic b1;
    logic [31:0] a0, b0, a0_run1, b0_run1, a0_u1;
    logic [5:0] op0;
    logic found;
    logic [31:0] l, ma, mb;
    logic [5:0] mo;
    int ecount;
    logic [5:0] eop;
    logic [15:0] eidx;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
    end
    mode[0] = 2'd0; mode[1] = 2'd1; mode[2] = 2'd1;
    start[0] = 1'b1;  // reset must win over start
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy[0]), 128'(0));
    chk("rst_done", 128'(done[0]), 128'(0));
    chk("rst_outputs", 128'({reg_one[0], reg_two[0], op[0], pass[0], fail_count[0],
                             fail_op[0], fail_index[0]}), 128'(0));
    start[0] = 1'b0;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Good ALU, VECTORS=4: 11*4*3 = 132 cycles.
    run(0, 1'b0, 1000, cyc, b1, a0, b0, op0);
    chk("t1_cycles", 128'(cyc), 128'(132));
    chk("t1_busy_after_accept", 128'(b1), 128'(1));
    chk("t1_pass", 128'(pass[0]), 128'(1));
    chk("t1_fail_count", 128'(fail_count[0]), 128'(0));
    chk("t1_busy_at_done", 128'(busy[0]), 128'(0));
    chk("t1_vec0_a", 128'(a0), 128'(lfsr_step(SEED)));
    chk("t1_vec0_b", 128'(b0), 128'(0));
    chk("t1_vec0_op", 128'(op0), 128'(0));
    a0_run1 = a0;
    b0_run1 = b0;

    // Reset mid-run during op 32, then restart.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (op[0] == 6'd32) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_reached_op32", 128'(found), 128'(1));
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("t4_rst_all_zero", 128'({reg_one[0], reg_two[0], op[0], busy[0], done[0], pass[0],
                                 fail_count[0], fail_op[0], fail_index[0]}), 128'(0));
    rst_n[0] = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 1000, cyc, b1, a0, b0, op0);
    chk("t4_restart_vec0_a", 128'(a0), 128'(a0_run1));
    chk("t4_restart_vec0_b", 128'(b0), 128'(b0_run1));
    chk("t4_restart_cycles", 128'(cyc), 128'(132));

    // xor stuck at 0, VECTORS=8.
    run(1, 1'b0, 2000, cyc, b1, a0, b0, op0);
    chk("t2_cycles", 128'(cyc), 128'(264));
    chk("t2_pass", 128'(pass[1]), 128'(0));
    chk("t2_fail_op", 128'(fail_op[1]), 128'(38));
    chk("t2_fail_index", 128'(fail_index[1]), 128'(0));
    chk("t2_fail_count", 128'(fail_count[1]), 128'(8));
    a0_u1 = a0;

    // start held high: no restart while busy, restart right after done.
    run(1, 1'b1, 2000, cyc, b1, a0, b0, op0);
    chk("t5_cycles", 128'(cyc), 128'(264));
    chk("t5_fail_count_end", 128'(fail_count[1]), 128'(8));
    @(negedge clk);
    chk("t5_restart_done_low", 128'(done[1]), 128'(0));
    chk("t5_restart_busy", 128'(busy[1]), 128'(1));
    chk("t5_restart_fail_cleared", 128'({fail_count[1], fail_op[1], fail_index[1]}), 128'(0));
    @(negedge clk);
    chk("t5_restart_vec0_a", 128'(reg_one[1]), 128'(a0_u1));
    start[1] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Same fault with STOP_ON_FAIL: first xor CHECK is vector 56 -> edge 171.
    run(2, 1'b0, 2000, cyc, b1, a0, b0, op0);
    chk("t3_cycles", 128'(cyc), 128'(171));
    chk("t3_fail_count", 128'(fail_count[2]), 128'(1));
    chk("t3_fail_op", 128'(fail_op[2]), 128'(38));
    chk("t3_fail_index", 128'(fail_index[2]), 128'(0));
    chk("t3_pass", 128'(pass[2]), 128'(0));
    chk("t3_no_op39", 128'(saw39), 128'(0));

    // sra implemented as srl: expected result from a bench model of the run.
    mode[0] = 2'd2;
    l = SEED; ecount = 0; eop = '0; eidx = '0;
    for (int p = 0; p < 11; p++) begin
      for (int v = 0; v < 4; v++) begin
        mo = op_at(p);
        ma = lfsr_step(l);
        if (mo == 6'd0 || mo == 6'd2 || mo == 6'd3) begin
          mb = {27'b0, v[4:0]};
          l = ma;
        end else begin
          mb = lfsr_step(ma);
          l = mb;
        end
        if (alu_model(ma, mb, mo, 2'd2) !== alu_model(ma, mb, mo, 2'd0)) begin
          if (ecount == 0) begin
            eop = mo;
            eidx = 16'(v);
          end
          ecount++;
        end
      end
    end
    run(0, 1'b0, 1000, cyc, b1, a0, b0, op0);
    chk("t6_cycles", 128'(cyc), 128'(132));
    chk("t6_fail_count", 128'(fail_count[0]), 128'(ecount));
    chk("t6_fail_op", 128'(fail_op[0]), 128'(eop));
    chk("t6_fail_index", 128'(fail_index[0]), 128'(eidx));
    chk("t6_pass", 128'(pass[0]), 128'(ecount == 0));
    chk("t6_sra_golden", 128'(alu_model(32'h8000_0000, 32'd4, 6'd3, 2'd0)),
        128'(32'hF800_0000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
